// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and types used by the fetch path and its helpers.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction-memory port, redirect input and decode handshake.
interface imem_fetch_ctrl_if;
  import rv32i_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            out_misalign;

  modport master (
    output imem_addr, out_valid, out_pc, out_instr, out_misalign,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_pc, out_instr, out_misalign,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry pc/instruction holding buffer; flush beats capture beats drain.
module fetch_skid_buf
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            capture,
  input  logic            drain,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      instr_d = in_instr;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: word addresses to a 1-cycle imem, skid-buffered
// decode handshake, redirects. Option macro: FETCH_MISALIGN_TRAP_EN.
//
// state   | meaning
// ST_RUN  | normal sequential fetch
// ST_TRAP | misaligned redirect taken; fetch halted until the next redirect
module imem_fetch_ctrl
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic               clk,
  input logic               rst,
  imem_fetch_ctrl_if.master fif
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] target;
  logic            redir, redir_misalign, in_trap;
  logic            issue, xfer, out_valid;
  logic            trap_out;
  logic [XLEN-1:0] trap_pc_out;
  logic            buf_valid, buf_capture, buf_drain;
  logic [XLEN-1:0] buf_pc, buf_instr;

  assign redir  = fif.redirect_valid;
  assign target = word_align(fif.redirect_pc);

`ifdef FETCH_MISALIGN_TRAP_EN
  fetch_state_e    state_q, state_d;
  logic            trap_pend_q, trap_pend_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;

  assign redir_misalign = redir && (fif.redirect_pc[1:0] != 2'b00);
  assign in_trap        = (state_q == ST_TRAP);
  assign trap_out       = trap_pend_q;
  assign trap_pc_out    = trap_pc_q;

  // The trap response is a single NOP beat; the state stays TRAP after it drains.
  always_comb begin
    state_d     = state_q;
    trap_pend_d = trap_pend_q;
    trap_pc_d   = trap_pc_q;
    if (redir) begin
      if (redir_misalign) begin
        state_d     = ST_TRAP;
        trap_pend_d = 1'b1;
        trap_pc_d   = fif.redirect_pc;
      end else begin
        state_d     = ST_RUN;
        trap_pend_d = 1'b0;
      end
    end else if (xfer && trap_pend_q) begin
      trap_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      trap_pend_q <= 1'b0;
      trap_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      trap_pend_q <= trap_pend_d;
      trap_pc_q   <= trap_pc_d;
    end
  end
`else
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^fif.redirect_pc[1:0];
  assign redir_misalign      = 1'b0;
  assign in_trap             = 1'b0;
  assign trap_out            = 1'b0;
  assign trap_pc_out         = '0;
`endif

  // A redirect masks out_valid, so no transfer can slip through in that cycle.
  assign out_valid   = (buf_valid | inflight_q | trap_out) & ~redir;
  assign xfer        = out_valid & fif.out_ready;
  assign issue       = ~in_trap & ~buf_valid & (~inflight_q | fif.out_ready);
  assign buf_capture = inflight_q & ~fif.out_ready & ~buf_valid;
  assign buf_drain   = buf_valid & xfer;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redir) begin
      if (!redir_misalign) begin
        inflight_d    = 1'b1;
        inflight_pc_d = target;
        pc_d          = target + XLEN'(4);
      end
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (redir),
    .capture  (buf_capture),
    .drain    (buf_drain),
    .in_pc    (inflight_pc_q),
    .in_instr (fif.imem_rdata),
    .valid    (buf_valid),
    .pc       (buf_pc),
    .instr    (buf_instr)
  );

  assign fif.imem_addr    = redir ? target : pc_q;
  assign fif.out_valid    = out_valid;
  assign fif.out_pc       = trap_out ? trap_pc_out : (buf_valid ? buf_pc : inflight_pc_q);
  assign fif.out_instr    = trap_out ? INSTR_NOP : (buf_valid ? buf_instr : fif.imem_rdata);
  assign fif.out_misalign = trap_out;

endmodule
